pc_sequencer: RTL
=================

# pc_sequencer

Multi-cycle program-counter sequencer for the RISC-V core. Owns the PC register and drives instruction fetch through a request/ready handshake with instruction memory. Issues one instruction at a time to decode/execute and waits for execute to finish. On completion it resolves conditional branches and jumps from the execute-stage flags and selects the next PC.

## Interface
- BITSIZE, 32, width of PC, immediate and jump target
- RESET_PC, 32'h0000_0000, PC loaded on reset

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  BITSIZE  fetch address (equals pc_cur)
- imem_ready  in  1  instruction data valid on imem_instr this cycle
- imem_instr  in  32  fetched instruction word
- instr_valid  out  1  one-cycle pulse: instr/pc_cur presented to decode
- instr  out  32  captured instruction
- pc_cur  out  BITSIZE  PC of the instruction in flight
- exec_done  in  1  execute finished; branch/flag inputs valid this cycle
- branch  in  1  instruction is a conditional branch
- funct3  in  3  branch condition
- zero_flag  in  1  ALU result zero
- n  in  1  ALU result negative
- imm  in  BITSIZE  sign-extended byte offset for branches
- jump  in  1  unconditional jump; overrides branch
- jump_target  in  BITSIZE  absolute jump destination
- halt  in  1  stop after the current instruction (sampled with exec_done)
- taken  out  1  one-cycle pulse: redirect taken
- fault  out  1  sticky: misaligned target
- halted  out  1  sequencer stopped
- retired  out  32  count of completed instructions

## Operation
- States: RESET, FETCH, ISSUE, EXEC, HALTED.
- RESET: lasts one cycle after rst deasserts. Then goes to FETCH.
- FETCH: imem_req=1 and imem_addr=pc_cur.
  - If imem_ready=1: capture imem_instr into instr and go to ISSUE.
  - Otherwise stay in FETCH, holding request and address stable.
- ISSUE: instr_valid=1 for exactly one cycle, then go to EXEC.
- EXEC: wait for exec_done=1. On that cycle:
  - Compute next PC (priority order):
    - jump=1 → jump_target
    - branch=1 and condition true → pc_cur + imm
    - otherwise → pc_cur + 4
  - Branch conditions by funct3: 000 BEQ = zero_flag; 001 BNE = !zero_flag; 100 BLT = n; 101 BGE = !n. Any other funct3 is not taken.
  - taken=1 only when the jump or branch path is selected.
  - retired increments.
  - If next PC[1:0] != 0: keep pc_cur unchanged, set fault, go to HALTED.
  - Else if halt=1: load next PC, go to HALTED.
  - Else: load next PC, go to FETCH.
- HALTED: absorbing state. halted=1, imem_req=0. Only rst exits it.
- Arithmetic:
  - All PC additions are modulo 2^BITSIZE; wrap-around is legal (e.g. 32'hFFFF_FFFC + 4 = 0).
  - imm is already sign-extended by the immediate generator.
  - retired wraps from 32'hFFFF_FFFF to 0.
- Ignored inputs:
  - imem_ready outside FETCH.
  - exec_done, branch, jump and halt outside EXEC.
  - branch when jump=1.

## Timing
- Reset values: state=RESET, pc_cur=RESET_PC, instr=0, imem_req=0, instr_valid=0, taken=0, fault=0, halted=0, retired=0.
- rst has priority over all other inputs on any cycle. Reset mid-fetch drops imem_req on the next edge, and the pending fetch is abandoned.
- Fetch latency: imem_req is asserted in the first cycle after RESET. If imem_ready arrives in the same cycle, instr_valid rises on the next cycle.
- Minimum instruction period is 3 cycles (FETCH, ISSUE, EXEC with exec_done=1 in its first cycle).
- pc_cur updates on the clock edge that samples exec_done. The next FETCH presents the new address in the following cycle.
- taken is registered and asserts in the cycle after exec_done, coincident with the first FETCH cycle of the target.
- imem_addr must not change while imem_req=1 and imem_ready=0.
- halted asserts in the cycle after the terminating exec_done.

## Structure
- Shared package riscv_pkg holds:
  - the state encoding typedef;
  - the FUNCT3 branch constants (BEQ/BNE/BLT/BGE);
  - PC_STEP=4.
- Sub-module branch_resolve is combinational: inputs (branch, jump, funct3, zero_flag, n, pc, imm, jump_target); outputs (next_pc, take, misaligned).
- pc_sequencer contains the FSM, the PC/instr registers and the retired counter.

## Test plan
- Reset then immediate ready:
  - Expect imem_addr=0 with imem_req=1.
  - instr_valid pulses one cycle later with instr = the supplied word.
  - exec_done with branch=0 → pc_cur=4, taken=0, retired=1.
- Fetch stall:
  - Hold imem_ready=0 for 5 cycles.
  - imem_req and imem_addr must stay constant, and no instr_valid.
- Branch sweep at pc=32'h100, imm=32'hFFFF_FFF0:
  - BEQ zero=1 → pc 32'hF0, taken=1.
  - BNE zero=1 → 32'h104.
  - BLT n=1 → 32'hF0.
  - BGE n=1 → 32'h104.
  - funct3=010 → 32'h104.
- Jump priority: jump=1, jump_target=32'h200, and branch BEQ zero=1 with imm=8 → pc_cur=32'h200.
- Misaligned jump_target=32'h202:
  - fault=1, halted=1, pc_cur unchanged, imem_req=0 thereafter.
  - rst clears both fault and halted.
- Wrap and halt:
  - pc=32'hFFFF_FFFC, sequential → pc 0.
  - halt=1 with exec_done → halted, no further imem_req.
  - Assert rst mid-FETCH → RESET state with pc=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding,
// branch condition codes and the sequential PC increment.
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between the sequencer (master) and instruction
// memory (slave).
interface pc_sequencer_if #(
  parameter int BITSIZE = 32
);
  logic               imem_req;
  logic [BITSIZE-1:0] imem_addr;
  logic               imem_ready;
  logic [31:0]        imem_instr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_instr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_instr
  );
endinterface

// File: rtl/pc_sequencer_branch_resolve.sv
// Combinational next-PC selection: jump beats a taken branch, which beats the
// sequential step. Also flags a target that is not word aligned.
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic                      branch,
  input  logic                      jump,
  input  logic [2:0]                funct3,
  input  logic                      zero_flag,
  input  logic                      n,
  input  logic        [BITSIZE-1:0] pc,
  input  logic signed [BITSIZE-1:0] imm,
  input  logic        [BITSIZE-1:0] jump_target,
  output logic        [BITSIZE-1:0] next_pc,
  output logic                      take,
  output logic                      misaligned
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero_flag;
      F3_BNE:  cond = !zero_flag;
      F3_BLT:  cond = n;
      F3_BGE:  cond = !n;
      default: cond = 1'b0;
    endcase
  end

  // Additions wrap modulo 2^BITSIZE by construction of the fixed-width sum.
  always_comb begin
    take    = 1'b0;
    next_pc = pc + BITSIZE'(PC_STEP);
    if (jump) begin
      take    = 1'b1;
      next_pc = jump_target;
    end else if (branch && cond) begin
      take    = 1'b1;
      next_pc = pc + $unsigned(imm);
    end
  end

  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: fetches one instruction, issues it, waits for
// execute to finish, then selects and loads the next PC.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int                 BITSIZE  = 32,
  parameter logic [BITSIZE-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  pc_sequencer_if.master      imem,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [BITSIZE-1:0]  pc_cur,
  input  logic                exec_done,
  input  logic                branch,
  input  logic [2:0]          funct3,
  input  logic                zero_flag,
  input  logic                n,
  input  logic [BITSIZE-1:0]  imm,
  input  logic                jump,
  input  logic [BITSIZE-1:0]  jump_target,
  input  logic                halt,
  output logic                taken,
  output logic                fault,
  output logic                halted,
  output logic [31:0]         retired
);

  state_t             state, state_nxt;
  logic               capture;
  logic               complete;
  logic [BITSIZE-1:0] next_pc;
  logic               take;
  logic               misaligned;

  branch_resolve #(
    .BITSIZE (BITSIZE)
  ) u_resolve (
    .branch      (branch),
    .jump        (jump),
    .funct3      (funct3),
    .zero_flag   (zero_flag),
    .n           (n),
    .pc          (pc_cur),
    .imm         (imm),
    .jump_target (jump_target),
    .next_pc     (next_pc),
    .take        (take),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_RESET: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem.imem_ready) begin
          capture   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (exec_done) begin
          complete  = 1'b1;
          state_nxt = (misaligned || halt) ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RESET;
    endcase
  end

  // A misaligned target retires the instruction but leaves the PC where it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_cur  <= RESET_PC;
      instr   <= '0;
      taken   <= 1'b0;
      fault   <= 1'b0;
      retired <= '0;
    end else begin
      taken <= complete && take;
      if (capture) begin
        instr <= imem.imem_instr;
      end
      if (complete) begin
        retired <= retired + 32'd1;
        if (misaligned) begin
          fault <= 1'b1;
        end else begin
          pc_cur <= next_pc;
        end
      end
    end
  end

  assign imem.imem_req  = (state == ST_FETCH);
  assign imem.imem_addr = pc_cur;
  assign instr_valid    = (state == ST_ISSUE);
  assign halted         = (state == ST_HALTED);

endmodule
